// File: rtl/audio_pkg.sv
// Shared widths and sample types for the audio output path.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned BCLK_DIV = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Valid/ready sample handshake between the volume stage and the I2S transmitter.
interface audio_i2s_tx_if
  import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W
) ();

  logic signed [SAMPLE_W-1:0] lft_in;
  logic signed [SAMPLE_W-1:0] rht_in;
  logic                       smpl_vld;
  logic                       smpl_rdy;

  modport master (
    output lft_in,
    output rht_in,
    output smpl_vld,
    input  smpl_rdy
  );

  modport slave (
    input  lft_in,
    input  rht_in,
    input  smpl_vld,
    output smpl_rdy
  );

endinterface

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: registered BCLK plus a strobe on the cycle the divider wraps.
module audio_bclk_gen
  import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = audio_pkg::BCLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  assign fall    = (div_cnt == DIV_LAST);
  assign div_nxt = fall ? '0 : div_cnt + 1'b1;

  // bclk is computed from the next count so it tracks the registered div_cnt exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bclk    <= (div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: one-pair holding buffer, frame shifter, repeat-on-underrun.
module audio_i2s_tx
  import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int unsigned BCLK_DIV = audio_pkg::BCLK_DIV
) (
    input  logic          clk,
    input  logic          rst,
    audio_i2s_tx_if.slave smpl,
    output logic          BCLK,
    output logic          LRCLK,
    output logic          SDout,
    output logic          frm_strt,
    output logic          underrun
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  logic                       fall;
  logic                       load;
  logic                       xfer;
  logic                       hold_full;
  logic                       hold_full_nxt;
  logic [CNT_W-1:0]           bit_cnt;
  logic [FRAME_W-1:0]         shifter;
  logic signed [SAMPLE_W-1:0] hold_l;
  logic signed [SAMPLE_W-1:0] hold_r;

  audio_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk (
    .clk (clk),
    .rst (rst),
    .bclk(BCLK),
    .fall(fall)
  );

  // Loading on the fall into bit 1 gives the I2S one-bit delay after LRCLK changes
  assign load = fall && (bit_cnt == '0);
  assign xfer = smpl.smpl_vld && smpl.smpl_rdy;

  always_comb begin
    hold_full_nxt = hold_full;
    if (load) hold_full_nxt = 1'b0;
    if (xfer) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      shifter       <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      hold_full     <= 1'b0;
      smpl.smpl_rdy <= 1'b0;
      frm_strt      <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (fall) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        shifter <= load ? {hold_l, hold_r} : shifter << 1;
      end
      // A load in the same cycle as a capture still sees the old hold contents
      if (xfer) begin
        hold_l <= smpl.lft_in;
        hold_r <= smpl.rht_in;
      end
      hold_full     <= hold_full_nxt;
      smpl.smpl_rdy <= !hold_full_nxt;
      frm_strt      <= load;
      underrun      <= load && !hold_full;
    end
  end

  assign LRCLK = bit_cnt[CNT_W-1];
  assign SDout = shifter[FRAME_W-1];

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed + randomized bench: cycle-level frame model and an I2S receiver decoding SDout.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic BCLK, LRCLK, SDout, frm_strt, underrun;

  audio_i2s_tx_if #(.SAMPLE_W(16)) smpl ();

  audio_i2s_tx #(
    .SAMPLE_W(16),
    .BCLK_DIV(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .smpl    (smpl),
    .BCLK    (BCLK),
    .LRCLK   (LRCLK),
    .SDout   (SDout),
    .frm_strt(frm_strt),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Frame timing with BCLK_DIV=8, 32 bits per frame: load happens n mod 256 == 8
  // edges after reset release.
  int unsigned n;
  bit          m_full, m_rdy, m_und, m_frm, m_xfer;
  stereo_t     m_hold;
  stereo_t     exp_q[$];
  logic [15:0] rx_word;
  logic        rx_prev_lr;
  logic        prev_bclk;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    bit load;
    @(posedge clk);
    if (rst) begin
      n = 0; m_full = 0; m_rdy = 0; m_und = 0; m_frm = 0; m_xfer = 0;
      m_hold = '0;
      exp_q.delete();
    end else begin
      n++;
      load   = ((n % 256) == 8);
      m_xfer = smpl.smpl_vld && m_rdy;
      m_und  = load && !m_full;
      m_frm  = load;
      if (load) begin
        exp_q.push_back(m_hold);
        m_full = 0;
      end
      if (m_xfer) begin
        m_hold = {smpl.lft_in, smpl.rht_in};
        m_full = 1;
      end
      m_rdy = !m_full;
    end
    #1;
    check("smpl_rdy", smpl.smpl_rdy, m_rdy);
    check("underrun", underrun, m_und);
    check("frm_strt", frm_strt, m_frm);
    check("bclk", BCLK, ((n % 8) >= 4));
    check("lrclk", LRCLK, (((n / 8) % 32) >= 16));
    if (rst) begin
      check("sdout_rst", SDout, 0);
      rx_word = '0; rx_prev_lr = 1'b0; prev_bclk = BCLK;
    end else begin
      if (BCLK && !prev_bclk) begin
        rx_word = {rx_word[14:0], SDout};
        if (LRCLK != rx_prev_lr) begin
          check("rx_word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            if (!rx_prev_lr) check("left_word", rx_word, $unsigned(exp_q[0].l));
            else begin
              check("right_word", rx_word, $unsigned(exp_q[0].r));
              void'(exp_q.pop_front());
            end
          end
          rx_word = '0;
        end
        rx_prev_lr = LRCLK;
      end
      prev_bclk = BCLK;
    end
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    run(cycles);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit done = 0;
    smpl.smpl_vld = 1'b1;
    smpl.lft_in   = l;
    smpl.rht_in   = r;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      done = m_xfer;
    end
    check("send_accepted", done, 1);
    smpl.smpl_vld = 1'b0;
  endtask

  task automatic wait_phase(input int unsigned p);
    for (int i = 0; i < 300 && (n % 256) != p; i++) step();
    check("phase_reached", n % 256, p);
  endtask

  initial begin
    rst = 1'b1;
    smpl.smpl_vld = 1'b0;
    smpl.lft_in   = '0;
    smpl.rht_in   = '0;
    rx_word = '0; rx_prev_lr = 1'b0; prev_bclk = 1'b0; n = 0;

    // idle after reset: zero frame with underrun at first load
    do_reset(3);
    run(280);

    // single pair before first load, then a starved repeat frame
    do_reset(2);
    send(16'hA5C3, 16'h0F0F);
    run(560);

    // continuously offered incrementing pairs: one transfer per frame
    for (int k = 0; k < 5; k++) send(16'h1000 + 16'(k), 16'h2000 + 16'(k));
    run(520);

    // extreme values then starvation: repeated with underrun each frame
    send(16'h8000, 16'h7FFF);
    run(800);

    // offer a pair exactly on the load edge while the buffer is empty
    wait_phase(7);
    smpl.smpl_vld = 1'b1;
    smpl.lft_in   = 16'h1234;
    smpl.rht_in   = 16'h5678;
    step();
    check("coincident_xfer", m_xfer, 1);
    smpl.smpl_vld = 1'b0;
    run(600);

    // randomized gaps and data
    for (int k = 0; k < 20; k++) begin
      run($urandom_range(0, 400));
      send(16'($urandom()), 16'($urandom()));
    end
    run(600);

    // one-cycle reset in the middle of the right slot
    send(16'hCAFE, 16'hBEEF);
    wait_phase(164);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rdy_after_rst", smpl.smpl_rdy, 1);
    send(16'h0F0F, 16'hF0F0);
    run(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
